// File: rtl/nibble_serial_logic_unit.sv
// Serial 32-bit logic unit: applies AND/OR/XOR/NOR to one SLICE-bit slice per cycle,
// LSB slice first, between a valid/ready operand handshake and a valid/ready result handshake.
module nibble_serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("nibble_serial_logic_unit: WIDTH must be an exact multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [1:0]       opr;
  logic [SLICE-1:0] x_slice;
  logic [SLICE-1:0] y_slice;
  logic [SLICE-1:0] slice_res;
  logic             accept;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0] o,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign accept    = in_valid && in_ready;
  assign x_slice   = xr[int'(cnt)*SLICE +: SLICE];
  assign y_slice   = yr[int'(cnt)*SLICE +: SLICE];
  assign slice_res = slice_op(opr, x_slice, y_slice);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it drops the instant reset asserts
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = (state == DONE);
    zero      = out_valid && ~|f;
  end

  // Result slices fill LSB-first; untouched slices keep the zero written at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      xr  <= '0;
      yr  <= '0;
      opr <= '0;
      f   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xr  <= x;
            yr  <= y;
            opr <= op;
            f   <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          f[int'(cnt)*SLICE +: SLICE] <= slice_res;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_logic_unit.sv
// Directed, table-driven bench for nibble_serial_logic_unit with hand-computed results
// plus sequences for backpressure, mid-operation reset and back-to-back operations.
module tb_nibble_serial_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  op;
    logic [31:0] exp_f;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[7];

  nibble_serial_logic_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Returns at the falling edge right after the accept edge
  task automatic applyStimulus(input logic [31:0] ax, input logic [31:0] ay, input logic [1:0] aop);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x = ax;
    y = ay;
    op = aop;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    op = 2'($urandom_range(3, 0));
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc;
    int res;
    int cyc;
    int last;
    int seen;
    logic [31:0] held_f;

    vecs[0] = '{32'h12345678, 32'h0F0F0F0F, 2'b01, 32'h1F3F5F7F, 1'b0};
    vecs[1] = '{32'h12345678, 32'h0F0F0F0F, 2'b00, 32'h02040608, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'h00000000, 1'b1};
    vecs[3] = '{32'h00000000, 32'h00000000, 2'b11, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{32'h12345678, 32'h0F0F0F0F, 2'b10, 32'h1D3B5977, 1'b0};
    vecs[5] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 2'b11, 32'h50505050, 1'b0};
    vecs[6] = '{32'hDEADBEEF, 32'h00000000, 2'b00, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    op = '0;
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_f", f, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Table of single operations with an always-ready consumer
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].op);
      checkOutput($sformatf("v%0d_f_cleared", i), f, 32'd0);
      if (i == 1) begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("v1_and_partial", f, 32'h00000008);
      end
      waitResult(lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat + ((i == 1) ? 2 : 0)), 32'd8);
      checkOutput($sformatf("v%0d_f", i), f, vecs[i].exp_f);
      checkOutput($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      @(negedge clk);
      checkOutput($sformatf("v%0d_in_ready_after", i), {31'd0, in_ready}, 32'd1);
      checkOutput($sformatf("v%0d_out_valid_after", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: result must hold while new operands are offered and ignored
    out_ready = 1'b0;
    applyStimulus(vecs[2].x, vecs[2].y, vecs[2].op);
    waitResult(lat);
    in_valid = 1'b1;
    x = 32'h0000FFFF;
    y = 32'h00FF00FF;
    op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_f", f, 32'h00000000);
      checkOutput("bp_zero", {31'd0, zero}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_f_held", f, 32'h00000000);
    @(negedge clk);
    checkOutput("bp_single_handshake", {31'd0, out_valid}, 32'd0);

    // Reset after the third RUN edge aborts the operation at once
    applyStimulus(vecs[0].x, vecs[0].y, vecs[0].op);
    repeat (3) @(negedge clk);
    checkOutput("mid_run_partial", f, 32'h00000F7F);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_run_rst_f", f, 32'd0);
    checkOutput("mid_run_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_run_rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_run_release_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("mid_run_no_partial_result", 32'(seen), 32'd0);

    // Reset while a result waits in DONE
    out_ready = 1'b0;
    applyStimulus(vecs[5].x, vecs[5].y, vecs[5].op);
    waitResult(lat);
    checkOutput("mid_done_f", f, 32'h50505050);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_done_rst_f", f, 32'd0);
    checkOutput("mid_done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_done_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h00000009, 32'h00000003, 2'b01);
    waitResult(lat);
    checkOutput("fresh_latency", 32'(lat), 32'd8);
    checkOutput("fresh_f", f, 32'h0000000B);
    checkOutput("fresh_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);

    // Back-to-back: nine non-accepting edges separate consecutive accept edges
    out_ready = 1'b1;
    acc = 0;
    res = 0;
    cyc = 0;
    last = -1;
    while ((acc < 3 || res < 3) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (acc == 3 && in_ready !== 1'b1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (res < 3) checkOutput($sformatf("b2b_f%0d", res), f, vecs[3 + res].exp_f);
        else checkOutput("b2b_extra_result", 32'(res + 1), 32'd3);
        res++;
      end
      if (in_ready === 1'b1 && acc < 3) begin
        x = vecs[3 + acc].x;
        y = vecs[3 + acc].y;
        op = vecs[3 + acc].op;
        in_valid = 1'b1;
        if (last >= 0) checkOutput("b2b_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        acc++;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", 32'(acc), 32'd3);
    checkOutput("b2b_results", 32'(res), 32'd3);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("b2b_no_duplicate", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
